// File: rtl/ecp5pll_phase_ctrl.sv
// rtl/ecp5pll_phase_ctrl.sv - ECP5 PLL dynamic phase-shift sequencer
module ecp5pll_phase_ctrl #(
    parameter int STEP_W       = 8,
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 1000
) (
    input  logic              clk_i,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_sel,
    input  logic              req_dir,
    input  logic [STEP_W-1:0] req_steps,
    input  logic              req_load,
    input  logic              pll_locked,
    output logic [1:0]        phasesel,
    output logic              phasedir,
    output logic              phasestep,
    output logic              phaseloadreg,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [STEP_W-1:0] steps_done
);

    localparam int MAX_A   = (SETUP_CYCLES > PULSE_CYCLES) ? SETUP_CYCLES : PULSE_CYCLES;
    localparam int MAX_B   = (GAP_CYCLES > LOCK_TIMEOUT) ? GAP_CYCLES : LOCK_TIMEOUT;
    localparam int CNT_MAX = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LOCK,
        SETUP,
        STEP_HI,
        STEP_LO,
        LOAD_HI,
        LOAD_LO,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  cnt;
    logic              lock_meta;
    logic              lock_sync;
    logic [STEP_W-1:0] steps_q;
    logic              load_q;
    logic              accept;
    logic              fail;
    logic              step_inc;
    logic              dispatch;
    logic              want_step;

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Dispatch decides the next pulse; every pulse start is gated on lock.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fail       = 1'b0;
        step_inc   = 1'b0;
        dispatch   = 1'b0;
        want_step  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept     = 1'b1;
                    state_next = lock_sync ? SETUP : WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                if (lock_sync) begin
                    state_next = SETUP;
                end else if (cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
                    state_next = DONE;
                    fail       = 1'b1;
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(SETUP_CYCLES - 1)) begin
                    dispatch  = 1'b1;
                    want_step = (steps_q != '0);
                end
            end
            STEP_HI: begin
                if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    state_next = STEP_LO;
                    step_inc   = 1'b1;
                end
            end
            STEP_LO: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    dispatch  = 1'b1;
                    want_step = (steps_done < steps_q);
                end
            end
            LOAD_HI: begin
                if (cnt == CNT_W'(PULSE_CYCLES - 1)) begin
                    state_next = LOAD_LO;
                end
            end
            LOAD_LO: begin
                if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
                    state_next = DONE;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase

        if (dispatch) begin
            if (want_step || load_q) begin
                if (!lock_sync) begin
                    state_next = DONE;
                    fail       = 1'b1;
                end else begin
                    state_next = want_step ? STEP_HI : LOAD_HI;
                end
            end else begin
                state_next = DONE;
            end
        end
    end

    // Cycle counter restarts on every state change so each state times itself.
    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (state_next != state || state == IDLE) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_sync <= 1'b0;
        end else begin
            lock_meta <= pll_locked;
            lock_sync <= lock_meta;
        end
    end

    always_ff @(posedge clk_i or posedge reset) begin
        if (reset) begin
            steps_q      <= '0;
            load_q       <= 1'b0;
            phasesel     <= 2'b00;
            phasedir     <= 1'b0;
            steps_done   <= '0;
            err          <= 1'b0;
            phasestep    <= 1'b0;
            phaseloadreg <= 1'b0;
            done         <= 1'b0;
        end else begin
            if (accept) begin
                steps_q    <= req_steps;
                load_q     <= req_load;
                phasesel   <= req_sel;
                phasedir   <= req_dir;
                steps_done <= '0;
                err        <= 1'b0;
            end else begin
                if (step_inc) begin
                    steps_done <= steps_done + STEP_W'(1);
                end
                if (fail) begin
                    err <= 1'b1;
                end
            end
            // Decoded from the next state so the pins are clean flop outputs.
            phasestep    <= (state_next == STEP_HI);
            phaseloadreg <= (state_next == LOAD_HI);
            done         <= (state_next == DONE);
        end
    end

    assign busy      = (state != IDLE);
    assign req_ready = (state == IDLE) && !reset;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// tb/tb_ecp5pll_phase_ctrl.sv - directed scoreboard bench for ecp5pll_phase_ctrl
module tb_ecp5pll_phase_ctrl;

    localparam int S  = 2;
    localparam int P  = 4;
    localparam int G  = 4;
    localparam int T  = 1000;
    localparam int PG = P + G;

    logic       clk_i      = 1'b0;
    logic       reset      = 1'b1;
    logic       req_valid  = 1'b0;
    logic       req_ready;
    logic [1:0] req_sel    = 2'b00;
    logic       req_dir    = 1'b0;
    logic [7:0] req_steps  = 8'd0;
    logic       req_load   = 1'b0;
    logic       pll_locked = 1'b1;
    logic [1:0] phasesel;
    logic       phasedir;
    logic       phasestep;
    logic       phaseloadreg;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] steps_done;

    int passed = 0;
    int total  = 0;

    typedef struct {
        int done_cyc;
        int err;
        int steps_done;
        int step_pulses;
        int load_pulses;
    } exp_t;

    exp_t sb[$];

    ecp5pll_phase_ctrl #(
        .STEP_W(8), .SETUP_CYCLES(S), .PULSE_CYCLES(P), .GAP_CYCLES(G), .LOCK_TIMEOUT(T)
    ) dut (
        .clk_i(clk_i), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps), .req_load(req_load),
        .pll_locked(pll_locked), .phasesel(phasesel), .phasedir(phasedir),
        .phasestep(phasestep), .phaseloadreg(phaseloadreg), .busy(busy), .done(done),
        .err(err), .steps_done(steps_done)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // lock_mode: 0 locked, 1 lock rises in cycle 49, 2 lock held low
    task automatic run_req(input string name, input logic [1:0] sel, input logic dir,
                           input int steps, input logic load, input int lock_mode,
                           input int drop_at, input int poke_at);
        exp_t e;
        exp_t got;
        int   b;
        int   r;
        int   r2;
        int   mism;
        int   sel_bad;
        int   overlap;
        int   rdy_bad;
        int   sp;
        int   lp;
        logic prev_s;
        logic prev_l;
        logic es;
        logic el;
        logic done_seen;

        if (lock_mode != 0) begin
            pll_locked = 1'b0;
            repeat (4) @(negedge clk_i);
        end
        b = (lock_mode == 1) ? 49 + 3 : 0;
        if (lock_mode == 2) begin
            e = '{T, 1, 0, 0, 0};
        end else if (drop_at >= 0) begin
            r = (drop_at - S) / PG + 1;
            e = '{S + r * PG, 1, r, r, 0};
        end else begin
            e = '{b + S + (steps + int'(load)) * PG, 0, steps, steps, int'(load)};
        end
        sb.push_back(e);

        check({name, " ready_before"}, req_ready, 1);
        req_sel   = sel;
        req_dir   = dir;
        req_steps = 8'(steps);
        req_load  = load;
        req_valid = 1'b1;
        @(posedge clk_i);
        #1 req_valid = 1'b0;

        got       = '{-1, -1, -1, 0, 0};
        done_seen = 1'b0;
        mism = 0; sel_bad = 0; overlap = 0; rdy_bad = 0; sp = 0; lp = 0;
        prev_s = 1'b0; prev_l = 1'b0;
        for (int c = 0; c < 4000 && !done_seen; c++) begin
            @(negedge clk_i);
            r  = c - b - S;
            es = (r >= 0) && (r / PG < e.step_pulses) && (r % PG < P);
            r2 = r - e.step_pulses * PG;
            el = (e.load_pulses != 0) && (r2 >= 0) && (r2 < P);
            if (phasestep !== es || phaseloadreg !== el) mism++;
            if (phasesel !== sel || phasedir !== dir) sel_bad++;
            if (phasestep === 1'b1 && phaseloadreg === 1'b1) overlap++;
            if (req_ready !== 1'b0 || busy !== 1'b1) rdy_bad++;
            if (phasestep === 1'b1 && !prev_s) sp++;
            if (phaseloadreg === 1'b1 && !prev_l) lp++;
            prev_s = phasestep;
            prev_l = phaseloadreg;
            if (done === 1'b1) begin
                done_seen      = 1'b1;
                got.done_cyc   = c;
                got.err        = int'(err);
                got.steps_done = int'(steps_done);
            end
            if (lock_mode == 1 && c == 49) pll_locked = 1'b1;
            if (c == drop_at) pll_locked = 1'b0;
            if (c == poke_at) begin
                req_valid = 1'b1;
                req_sel   = ~sel;
                req_dir   = ~dir;
            end else if (c == poke_at + 1) begin
                req_valid = 1'b0;
                req_sel   = sel;
                req_dir   = dir;
            end
        end
        req_valid       = 1'b0;
        got.step_pulses = sp;
        got.load_pulses = lp;

        check({name, " done_seen"}, done_seen, 1);
        e = sb.pop_front();
        check({name, " done_cycle"}, got.done_cyc, e.done_cyc);
        check({name, " err"}, got.err, e.err);
        check({name, " steps_done"}, got.steps_done, e.steps_done);
        check({name, " step_pulses"}, got.step_pulses, e.step_pulses);
        check({name, " load_pulses"}, got.load_pulses, e.load_pulses);
        check({name, " pulse_profile_errs"}, mism, 0);
        check({name, " sel_dir_changes"}, sel_bad, 0);
        check({name, " overlap_cycles"}, overlap, 0);
        check({name, " ready_busy_errs"}, rdy_bad, 0);

        @(negedge clk_i);
        check({name, " done_one_cycle"}, done, 0);
        check({name, " idle_ready"}, req_ready, 1);
        check({name, " idle_busy"}, busy, 0);
        check({name, " err_held"}, err, e.err);

        if (pll_locked !== 1'b1) begin
            pll_locked = 1'b1;
            repeat (4) @(negedge clk_i);
        end
    endtask

    initial begin
        int nd;

        repeat (3) @(negedge clk_i);
        check("reset_outputs_zero",
              {22'd0, phasesel, phasedir, phasestep, phaseloadreg, busy, done, err, req_ready,
               (steps_done != 8'd0)}, 0);
        reset = 1'b0;
        #1;
        check("ready_after_release", req_ready, 1);
        repeat (4) @(negedge clk_i);

        run_req("basic",      2'd2, 1'b1, 3,   1'b0, 0, -1, 5);
        run_req("load_only",  2'd1, 1'b0, 0,   1'b1, 0, -1, -1);
        run_req("empty",      2'd3, 1'b1, 0,   1'b0, 0, -1, -1);
        run_req("step_load",  2'd0, 1'b1, 1,   1'b1, 0, -1, 3);
        run_req("lock_late",  2'd2, 1'b0, 2,   1'b0, 1, -1, -1);
        run_req("lock_tmo",   2'd1, 1'b1, 4,   1'b1, 2, -1, -1);
        run_req("lock_drop",  2'd3, 1'b0, 5,   1'b0, 0, 10, -1);
        run_req("max_steps",  2'd0, 1'b0, 255, 1'b0, 0, -1, -1);

        req_sel   = 2'd1;
        req_dir   = 1'b1;
        req_steps = 8'd3;
        req_load  = 1'b0;
        req_valid = 1'b1;
        @(posedge clk_i);
        #1 req_valid = 1'b0;
        repeat (4) @(negedge clk_i);
        check("rst_mid pulse_high", phasestep, 1);
        reset = 1'b1;
        #1;
        check("rst_mid phasestep_drop", phasestep, 0);
        check("rst_mid busy", busy, 0);
        check("rst_mid done", done, 0);
        @(negedge clk_i);
        reset = 1'b0;
        #1;
        check("rst_mid ready_after", req_ready, 1);
        nd = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i);
            if (done === 1'b1 || phasestep === 1'b1) nd++;
        end
        check("rst_mid no_done_no_pulse", nd, 0);

        run_req("post_reset", 2'd1, 1'b1, 1, 1'b0, 0, -1, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ecp5pll_phase_ctrl.md
ECP5PLL_PHASE_CTRL -- requirements
Module: ecp5pll_phase_ctrl

Interface
REQ-001 Parameter STEP_W, default 8, width of the step-count request.
REQ-002 Parameter SETUP_CYCLES, default 2, cycles phasesel/phasedir are held stable before the first pulse.
REQ-003 Parameter PULSE_CYCLES, default 4, high time of each phasestep/phaseloadreg pulse.
REQ-004 Parameter GAP_CYCLES, default 4, low time after each pulse.
REQ-005 Parameter LOCK_TIMEOUT, default 1000, max cycles spent waiting for lock.
REQ-006 Clocking: one clock; reset is asynchronous and active-high.
REQ-007 clk_i  in  1  system clock, same domain as the PLL control pins.
REQ-008 reset  in  1  asynchronous active-high reset.
REQ-009 req_valid  in  1  request a phase adjustment.
REQ-010 req_ready  out  1  request accepted when req_valid and req_ready are both high on a clk_i edge.
REQ-011 req_sel  in  2  output channel index 0..3, driven unchanged onto phasesel.
REQ-012 req_dir  in  1  phase direction, driven unchanged onto phasedir.
REQ-013 req_steps  in  STEP_W  number of phasestep pulses; 0 is legal.
REQ-014 req_load  in  1  issue one phaseloadreg pulse after the steps.
REQ-015 pll_locked  in  1  PLL lock indicator; asynchronous, double-flop synchronised internally.
REQ-016 phasesel  out  2  to the PLL wrapper.
REQ-017 phasedir  out  1  to the PLL wrapper.
REQ-018 phasestep  out  1  to the PLL wrapper.
REQ-019 phaseloadreg  out  1  to the PLL wrapper.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle completion pulse.
REQ-022 err  out  1  valid with done: 1 = timeout or lock lost.
REQ-023 steps_done  out  STEP_W  count of phasestep pulses issued for the current or last request.

Function
REQ-024 The block SHALL implement these states: IDLE, WAIT_LOCK, SETUP, STEP_HI, STEP_LO, LOAD_HI, LOAD_LO and DONE.
REQ-025 IDLE: req_ready=1; on accept, capture sel/dir/steps/load, latch phasesel/phasedir, clear steps_done, go SETUP when synced lock=1, otherwise go WAIT_LOCK.
REQ-026 WAIT_LOCK: go SETUP when synced lock=1; after LOCK_TIMEOUT cycles go DONE with err=1, issuing no pulses.
REQ-027 SETUP: last SETUP_CYCLES cycles, then go STEP_HI if steps>0, else LOAD_HI if load=1, else DONE.
REQ-028 STEP_HI: phasestep=1 for exactly PULSE_CYCLES; steps_done increments on exit; then go STEP_LO.
REQ-029 STEP_LO: phasestep=0 for GAP_CYCLES; then go STEP_HI if steps_done<steps, else LOAD_HI if load=1, else DONE.
REQ-030 LOAD_HI and LOAD_LO: phaseloadreg=1 for PULSE_CYCLES, then 0 for GAP_CYCLES, then go DONE.
REQ-031 Lock check: on every transition into STEP_HI or LOAD_HI, if synced lock=0, go DONE with err=1 instead; a pulse already started always completes its full PULSE_CYCLES.
REQ-032 DONE: one cycle with done=1; err is valid this cycle and held until the next accept; then go IDLE.
REQ-033 phasesel and phasedir SHALL be constant from accept until IDLE is re-entered.
REQ-034 phasestep and phaseloadreg SHALL be registered outputs, glitch-free, and never high at the same time.
REQ-035 Latency with lock present: done in cycle SETUP_CYCLES + steps*(PULSE_CYCLES+GAP_CYCLES) + load*(PULSE_CYCLES+GAP_CYCLES), where cycle 0 is the first cycle after the accept edge.
REQ-036 Requests presented while busy SHALL be ignored (req_ready=0); there is no queueing.
REQ-037 Counters SHALL be sized to hold their maximum parameter value; steps_done SHALL NOT wrap (max steps = 2^STEP_W-1).

Reset
REQ-038 Asynchronous reset SHALL force IDLE.
REQ-039 During reset all outputs SHALL be 0, except req_ready=1 after release.
REQ-040 A reset asserted mid-pulse SHALL drop phasestep/phaseloadreg immediately; no done pulse is issued for the aborted request.

Verification
REQ-041 Defaults, lock=1, sel=2, dir=1, steps=3, load=0 -> phasestep high in cycles 2-5, 10-13 and 18-21; done=1, err=0 in cycle 26; steps_done=3; phasesel=2 throughout.
REQ-042 steps=0, load=1 -> phasestep never high; phaseloadreg high in cycles 2-5; done in cycle 10.
REQ-043 steps=0, load=0 -> done in cycle 2, no pulses.
REQ-044 lock=0 at accept, lock rises 50 cycles later -> first pulse starts after the synced lock plus SETUP_CYCLES; with lock held low -> done with err=1 after 1000 cycles, no pulses.
REQ-045 steps=5, lock dropped during the 2nd pulse -> 2nd pulse completes at 4 cycles, no 3rd pulse, done with err=1, steps_done=2.
REQ-046 Reset asserted in the middle of STEP_HI -> phasestep=0 immediately, no done, req_ready=1 after release; req_valid while busy -> no effect.
